// File: rtl/divisor_secuencial_4b.sv
// Sequential restoring divider: one quotient bit per clock with a start/busy/done handshake.
// Optional macro DIVISOR_EARLY_EXIT_EN: when num < den the CALC phase is skipped entirely.
module divisor_secuencial_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rest
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] den_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] new_rem;
    logic [WIDTH-1:0] new_quo;

    // One restoring step; the partial remainder stays below den, so the
    // subtraction result always fits in WIDTH bits.
    always_comb begin
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        fits    = (shifted >= {1'b0, den_reg});
        new_rem = fits ? (shifted[WIDTH-1:0] - den_reg) : shifted[WIDTH-1:0];
        new_quo = {quo_reg[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (den == '0) begin
                        next_state = DONE;
                    end
`ifdef DIVISOR_EARLY_EXIT_EN
                    else if (num < den) begin
                        next_state = DONE;
                    end
`endif
                    else begin
                        next_state = CALC;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Operands are captured only on an accepted start; visible outputs change only when entering DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            den_reg  <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
            count    <= '0;
            result   <= '0;
            rest     <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        den_reg <= den;
                        if (den == '0) begin
                            result   <= '1;
                            rest     <= num;
                            div_zero <= 1'b1;
                        end
`ifdef DIVISOR_EARLY_EXIT_EN
                        else if (num < den) begin
                            result   <= '0;
                            rest     <= num;
                            div_zero <= 1'b0;
                        end
`endif
                        else begin
                            rem_reg <= '0;
                            quo_reg <= num;
                            count   <= CW'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    rem_reg <= new_rem;
                    quo_reg <= new_quo;
                    count   <= count - 1'b1;
                    if (count == '0) begin
                        result   <= new_quo;
                        rest     <= new_rem;
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
